seven_seg_cathode_driver: RTL and testbench

Segment-side counterpart to the anode scanner. It consumes the scanner's active-low one-hot anode vector and drives the active-low cathode/decimal-point lines with the pattern for the currently selected digit.
- Holds a double-buffered 4-digit hex value. New values are committed only at frame start, so no torn frames.
- Blanks segments after every anode change to suppress ghosting.
- Supports optional leading-zero suppression.

---
 rtl/seven_seg_pkg.sv | 42 ++++
 rtl/seven_seg_cathode_driver_hex_to_seg.sv | 11 +
 rtl/seven_seg_cathode_driver.sv | 103 ++++++++++
 tb/tb_seven_seg_cathode_driver.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/seven_seg_pkg.sv
// seven_seg_pkg: shared segment order, glyph table and anode codes for the display path
package seven_seg_pkg;

    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;

    localparam logic [6:0] SEG_OFF = 7'h7F;

    localparam logic [3:0] DIG0       = 4'b1110;
    localparam logic [3:0] DIG1       = 4'b1101;
    localparam logic [3:0] DIG2       = 4'b1011;
    localparam logic [3:0] DIG3       = 4'b0111;
    localparam logic [3:0] ANODE_IDLE = 4'b1111;

    localparam logic [15:0][6:0] HEX_GLYPH = {
        7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110,
        7'b0000011, 7'b0001000, 7'b0010000, 7'b0000000,
        7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001,
        7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
    };

    typedef struct packed {
        logic       valid;
        logic [1:0] idx;
    } anode_sel_t;

    function automatic anode_sel_t decode_anode(input logic [3:0] a);
        case (a)
            DIG0:    return '{valid: 1'b1, idx: 2'd0};
            DIG1:    return '{valid: 1'b1, idx: 2'd1};
            DIG2:    return '{valid: 1'b1, idx: 2'd2};
            DIG3:    return '{valid: 1'b1, idx: 2'd3};
            default: return '{valid: 1'b0, idx: 2'd0};
        endcase
    endfunction

endpackage

// File: rtl/seven_seg_cathode_driver_hex_to_seg.sv
// hex_to_seg: combinational nibble to active-low {g..a} glyph
module hex_to_seg
    import seven_seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = HEX_GLYPH[nibble];

endmodule

// File: rtl/seven_seg_cathode_driver.sv
// seven_seg_cathode_driver: double-buffered hex cathode driver with anti-ghost blanking
module seven_seg_cathode_driver
    import seven_seg_pkg::*;
#(
    parameter int BLANK_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  anode,
    input  logic [15:0] value,
    input  logic [3:0]  dp,
    input  logic        load,
    input  logic        lz_blank,
    output logic [6:0]  cathode,
    output logic        dp_n,
    output logic        commit,
    output logic        anode_err
);

    localparam int CW = BLANK_CYCLES > 0 ? $clog2(BLANK_CYCLES + 1) : 1;

    logic [3:0]    anode_r;
    logic [15:0]   shadow_val;
    logic [15:0]   active_val;
    logic [3:0]    shadow_dp;
    logic [3:0]    active_dp;
    logic          pending;
    logic [CW-1:0] cnt;
    anode_sel_t    sel;
    logic          change;
    logic          commit_now;
    logic [3:0]    low_bits;
    logic [3:0]    nib;
    logic [6:0]    glyph;
    logic          lz_hide;

    assign sel        = decode_anode(anode);
    assign change     = anode != anode_r;
    assign commit_now = change && anode == DIG0 && pending;
    assign low_bits   = ~anode;
    assign nib        = active_val[{sel.idx, 2'b00} +: 4];
    assign lz_hide    = lz_blank && sel.idx != 2'd0 && (active_val >> {sel.idx, 2'b00}) == 16'h0;

    hex_to_seg u_hex_to_seg (
        .nibble (nib),
        .seg    (glyph)
    );

    // Track the previous anode and flag codes with more than one digit selected
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            anode_r   <= ANODE_IDLE;
            anode_err <= 1'b0;
        end else begin
            anode_r   <= anode;
            anode_err <= (low_bits & (low_bits - 4'd1)) != 4'd0;
        end
    end

    // Shadow captures every load; active only swaps in at a frame start so a frame is never torn
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow_val <= '0;
            shadow_dp  <= '0;
            active_val <= '0;
            active_dp  <= '0;
            pending    <= 1'b0;
            commit     <= 1'b0;
        end else begin
            if (load) begin
                shadow_val <= value;
                shadow_dp  <= dp;
            end
            if (commit_now) begin
                active_val <= shadow_val;
                active_dp  <= shadow_dp;
            end
            pending <= load || (pending && !commit_now);
            commit  <= commit_now;
        end
    end

    // Keep segments dark after every anode change, then drive the selected digit
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt     <= '0;
            cathode <= SEG_OFF;
            dp_n    <= 1'b1;
        end else if (change) begin
            cnt     <= CW'(BLANK_CYCLES);
            cathode <= SEG_OFF;
            dp_n    <= 1'b1;
        end else if (cnt != '0) begin
            cnt     <= cnt - CW'(1);
            cathode <= SEG_OFF;
            dp_n    <= 1'b1;
        end else begin
            cathode <= (!sel.valid || lz_hide) ? SEG_OFF : glyph;
            dp_n    <= sel.valid ? ~active_dp[sel.idx] : 1'b1;
        end
    end

endmodule

// File: tb/tb_seven_seg_cathode_driver.sv
// tb_seven_seg_cathode_driver: directed checks of commit, blanking, decode and leading-zero logic
module tb_seven_seg_cathode_driver;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  anode;
    logic [15:0] value;
    logic [3:0]  dp;
    logic        load;
    logic        lz_blank;
    logic [6:0]  cathode;
    logic        dp_n;
    logic        commit;
    logic        anode_err;

    int tests = 0;
    int fails = 0;

    seven_seg_cathode_driver #(.BLANK_CYCLES(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .anode     (anode),
        .value     (value),
        .dp        (dp),
        .load      (load),
        .lz_blank  (lz_blank),
        .cathode   (cathode),
        .dp_n      (dp_n),
        .commit    (commit),
        .anode_err (anode_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called at a negedge: select anode a, expect 5 dark clocks then the glyph, 20-clock dwell
    task automatic show(input string tag, input logic [3:0] a, input logic [6:0] seg,
                        input logic exp_dp_n, input logic exp_commit);
        anode = a;
        @(negedge clk);
        load = 1'b0;
        check({tag, ".commit"}, 16'(commit), 16'(exp_commit));
        check({tag, ".err"}, 16'(anode_err), 16'd0);
        check({tag, ".dark1"}, 16'(cathode), 16'h7F);
        @(negedge clk);
        check({tag, ".commit_off"}, 16'(commit), 16'd0);
        repeat (3) @(negedge clk);
        check({tag, ".dark5"}, 16'(cathode), 16'h7F);
        check({tag, ".dp_dark"}, 16'(dp_n), 16'd1);
        @(negedge clk);
        check({tag, ".seg"}, 16'(cathode), 16'(seg));
        check({tag, ".dp_n"}, 16'(dp_n), 16'(exp_dp_n));
        repeat (14) @(negedge clk);
    endtask

    initial begin
        reset    = 1'b1;
        anode    = 4'b1111;
        value    = '0;
        dp       = '0;
        load     = 1'b0;
        lz_blank = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_hold.seg", 16'(cathode), 16'h7F);
        reset = 1'b0;
        @(negedge clk);
        check("rst.seg", 16'(cathode), 16'h7F);
        check("rst.dp_n", 16'(dp_n), 16'd1);
        check("rst.commit", 16'(commit), 16'd0);
        check("rst.err", 16'(anode_err), 16'd0);

        value = 16'h12AF;
        dp    = 4'b0001;
        load  = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (2) @(negedge clk);
        check("idle.seg", 16'(cathode), 16'h7F);
        check("idle.commit", 16'(commit), 16'd0);
        show("pre_frame_d1", 4'b1101, 7'b1000000, 1'b1, 1'b0);

        show("f1_d0", 4'b1110, 7'b0001110, 1'b0, 1'b1);
        show("f1_d1", 4'b1101, 7'b0001000, 1'b1, 1'b0);
        show("f1_d2", 4'b1011, 7'b0100100, 1'b1, 1'b0);
        show("f1_d3", 4'b0111, 7'b1111001, 1'b1, 1'b0);

        value = 16'h0000;
        dp    = 4'b0000;
        load  = 1'b1;
        @(negedge clk);
        value = 16'h0042;
        dp    = 4'b0100;
        @(negedge clk);
        load     = 1'b0;
        lz_blank = 1'b1;
        @(negedge clk);
        show("lz_d0", 4'b1110, 7'b0100100, 1'b1, 1'b1);
        show("lz_d1", 4'b1101, 7'b0011001, 1'b1, 1'b0);
        show("lz_d2", 4'b1011, 7'h7F, 1'b0, 1'b0);
        show("lz_d3", 4'b0111, 7'h7F, 1'b1, 1'b0);

        value = 16'h3456;
        dp    = 4'b0000;
        load  = 1'b1;
        @(negedge clk);
        load = 1'b0;
        @(negedge clk);
        value = 16'h0789;
        load  = 1'b1;
        show("same_d0", 4'b1110, 7'b0000010, 1'b1, 1'b1);
        show("same_d1", 4'b1101, 7'b0010010, 1'b1, 1'b0);
        show("same_d2", 4'b1011, 7'b0011001, 1'b1, 1'b0);
        show("same_d3", 4'b0111, 7'b0110000, 1'b1, 1'b0);
        show("next_d0", 4'b1110, 7'b0010000, 1'b1, 1'b1);
        show("next_d3", 4'b0111, 7'h7F, 1'b1, 1'b0);

        anode = 4'b1100;
        @(negedge clk);
        check("bad.err", 16'(anode_err), 16'd1);
        check("bad.seg", 16'(cathode), 16'h7F);
        repeat (8) @(negedge clk);
        check("bad_hold.err", 16'(anode_err), 16'd1);
        check("bad_hold.seg", 16'(cathode), 16'h7F);
        check("bad_hold.dp_n", 16'(dp_n), 16'd1);
        show("recover_d0", 4'b1110, 7'b0010000, 1'b1, 1'b0);

        value = 16'hBEEF;
        dp    = 4'b1111;
        load  = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        check("mid_rst.seg", 16'(cathode), 16'h7F);
        check("mid_rst.dp_n", 16'(dp_n), 16'd1);
        check("mid_rst.commit", 16'(commit), 16'd0);
        @(negedge clk);
        reset = 1'b0;
        show("post_rst_d0", 4'b1110, 7'b1000000, 1'b1, 1'b0);
        show("post_rst_d1", 4'b1101, 7'h7F, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
